h264recon4x4: RTL and testbench

//  Reconstruct-side partner of the intra 4x4 luma predictor.
//  - Stores each prediction base row (BASEI) the predictor emits.
//  - Adds the matching inverse-transformed residual row, clips the result
//    to 0..255 and outputs the reconstructed row.
//  - Returns the rightmost pixel of every row to the predictor as left-

---
 rtl/h264recon4x4.sv | 213 +++++++++++++++++++++
 tb/tb_h264recon4x4.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h264recon4x4.sv
// ---------------------------------------------------------------------------
// h264recon4x4
// Reconstruction stage paired with the intra 4x4 luma predictor.
// Base rows from the predictor are queued in a small FIFO. Each accepted
// residual row is added to the oldest queued base row, clipped to 0..255 and
// presented downstream. The rightmost pixel of each delivered row goes back
// to the predictor as left-neighbour feedback.
//
// Optional build macro: H264_RECON_CHECK_EN. When it is defined, a sticky
// protocol/clip error flag is built on ERRO. When it is undefined, ERRO is
// tied low.
//
// Ports:
//   CLK       in   pixel clock
//   RESETN    in   asynchronous active-low reset
//   BSTROBEI  in   base row valid
//   BASEI     in   [31:0] prediction row, pixel0 in [7:0]
//   BREADY    out  base FIFO can take a row this cycle
//   STROBEI   in   residual row valid
//   DATAI     in   [35:0] 4 x 9-bit signed residual, res0 in [8:0]
//   READYI    out  residual row accepted this cycle if STROBEI=1
//   READYO    in   downstream can take a row
//   STROBEO   out  reconstructed row valid
//   DATAO     out  [31:0] reconstructed row, pixel0 in [7:0]
//   ROWO      out  [1:0] row index within the 4x4 block
//   BLKDONE   out  STROBEO on the last row of the block
//   FBSTROBE  out  feedback pixel valid (one pulse per delivered row)
//   FEEDBO    out  [7:0] feedback pixel = DATAO[31:24]
//   ERRO      out  sticky error flag
// ---------------------------------------------------------------------------
module h264recon4x4 #(
    parameter int BDEPTH = 8,
    parameter int BAW    = 3
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        BSTROBEI,
    input  logic [31:0] BASEI,
    output logic        BREADY,
    input  logic        STROBEI,
    input  logic [35:0] DATAI,
    output logic        READYI,
    input  logic        READYO,
    output logic        STROBEO,
    output logic [31:0] DATAO,
    output logic [1:0]  ROWO,
    output logic        BLKDONE,
    output logic        FBSTROBE,
    output logic [7:0]  FEEDBO,
    output logic        ERRO
);

    // Base-row FIFO
    logic [31:0]    r_mem [BDEPTH];
    logic [BAW-1:0] r_wptr;
    logic [BAW-1:0] r_rptr;
    logic [BAW:0]   r_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_stall;
    logic w_accept;

    // Pipeline registers
    logic             r_s1v;
    logic [3:0][10:0] r_sum;
    logic             r_s2v;
    logic [31:0]      r_data;
    logic [1:0]       r_row;

    logic [3:0][10:0] w_sum;
    logic [31:0]      w_clip;
    logic [31:0]      w_base;

    // Depth is a power of two, so the count MSB is set only when full.
    assign w_full   = r_cnt[BAW];
    assign w_empty  = (r_cnt == '0);
    assign w_stall  = r_s2v & ~READYO;
    assign READYI   = ~w_stall & ~w_empty;
    assign w_accept = STROBEI & READYI;
    assign w_pop    = w_accept;
    assign BREADY   = ~w_full | w_pop;
    assign w_push   = BSTROBEI & BREADY;
    assign w_base   = r_mem[r_rptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= BASEI;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Unsigned base plus sign-extended residual; range -256..510 fits 11 bits.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = {3'b000, w_base[8*i +: 8]}
                     + {{2{DATAI[9*i+8]}}, DATAI[9*i +: 9]};
        end
    end

    // Clip: negative -> 0, above 255 -> 255.
    always_comb begin
        w_clip = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_sum[i][10]) begin
                w_clip[8*i +: 8] = 8'h00;
            end else if (r_sum[i][9:8] != 2'b00) begin
                w_clip[8*i +: 8] = 8'hFF;
            end else begin
                w_clip[8*i +: 8] = r_sum[i][7:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_s1v  <= 1'b0;
            r_sum  <= '0;
            r_s2v  <= 1'b0;
            r_data <= '0;
            r_row  <= 2'd0;
        end else begin
            if (!w_stall) begin
                r_s1v <= w_accept;
                if (w_accept) begin
                    r_sum <= w_sum;
                end
                r_s2v <= r_s1v;
                if (r_s1v) begin
                    r_data <= w_clip;
                end
            end
            if (r_s2v && READYO) begin
                r_row <= r_row + 2'd1;
            end
        end
    end

    assign STROBEO  = r_s2v;
    assign DATAO    = r_data;
    assign ROWO     = r_row;
    assign BLKDONE  = r_s2v & (r_row == 2'd3);
    assign FBSTROBE = r_s2v & READYO;
    assign FEEDBO   = r_data[31:24];

`ifdef H264_RECON_CHECK_EN
    typedef enum logic {StOk, StErr} err_state_e;

    err_state_e r_err_state;
    logic       r_erro;
    logic       w_any_clip;
    logic       w_err_event;

    always_comb begin
        w_any_clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_any_clip = w_any_clip | (r_sum[i][10:8] != 3'b000);
        end
    end

    // Dropped base push, residual with nothing to add to, or a clip entering stage 2.
    assign w_err_event = (BSTROBEI & ~BREADY)
                       | (STROBEI & w_empty)
                       | (r_s1v & ~w_stall & w_any_clip);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_err_state <= StOk;
            r_erro      <= 1'b0;
        end else begin
            case (r_err_state)
                StOk: begin
                    if (w_err_event) begin
                        r_err_state <= StErr;
                        r_erro      <= 1'b1;
                    end
                end
                default: begin
                    r_err_state <= StErr;
                    r_erro      <= 1'b1;
                end
            endcase
        end
    end

    assign ERRO = r_erro;
`else
    assign ERRO = 1'b0;
`endif

endmodule

// File: tb/tb_h264recon4x4.sv
module tb_h264recon4x4;

    logic        CLK;
    logic        RESETN;
    logic        BSTROBEI;
    logic [31:0] BASEI;
    logic        BREADY;
    logic        STROBEI;
    logic [35:0] DATAI;
    logic        READYI;
    logic        READYO;
    logic        STROBEO;
    logic [31:0] DATAO;
    logic [1:0]  ROWO;
    logic        BLKDONE;
    logic        FBSTROBE;
    logic [7:0]  FEEDBO;
    logic        ERRO;

    int n_checks;
    int n_errors;
    int fb_count;

`ifdef H264_RECON_CHECK_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    h264recon4x4 #(.BDEPTH(8), .BAW(3)) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .BSTROBEI (BSTROBEI),
        .BASEI    (BASEI),
        .BREADY   (BREADY),
        .STROBEI  (STROBEI),
        .DATAI    (DATAI),
        .READYI   (READYI),
        .READYO   (READYO),
        .STROBEO  (STROBEO),
        .DATAO    (DATAO),
        .ROWO     (ROWO),
        .BLKDONE  (BLKDONE),
        .FBSTROBE (FBSTROBE),
        .FEEDBO   (FEEDBO),
        .ERRO     (ERRO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge; inputs change and outputs are
    // sampled there.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        BSTROBEI = 1'b0;
        STROBEI  = 1'b0;
        BASEI    = '0;
        DATAI    = '0;
        READYO   = 1'b1;
        RESETN   = 1'b0;
        step();
        step();
        RESETN = 1'b1;
        step();
    endtask

    task automatic push_base(input logic [31:0] b);
        BSTROBEI = 1'b1;
        BASEI    = b;
        step();
        BSTROBEI = 1'b0;
    endtask

    function automatic logic [35:0] res4(input logic [8:0] r3, input logic [8:0] r2,
                                         input logic [8:0] r1, input logic [8:0] r0);
        return {r3, r2, r1, r0};
    endfunction

    logic [31:0] t3_base [4];
    logic [35:0] t3_res  [4];
    logic [31:0] t3_exp  [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        RESETN   = 1'b0;
        #2;

        // Reset state
        do_reset();
        check("rst_bready",  BREADY,  1);
        check("rst_readyi",  READYI,  0);
        check("rst_strobeo", STROBEO, 0);
        check("rst_datao",   DATAO,   0);
        check("rst_rowo",    ROWO,    0);
        check("rst_erro",    ERRO,    0);

        // 1: single row, +5 on every pixel, two-cycle latency
        push_base(32'h80808080);
        STROBEI = 1'b1;
        DATAI   = res4(9'd5, 9'd5, 9'd5, 9'd5);
        check("t1_readyi", READYI, 1);
        step();
        STROBEI = 1'b0;
        check("t1_n1_strobeo", STROBEO, 0);
        step();
        check("t1_strobeo", STROBEO, 1);
        check("t1_datao",   DATAO,   32'h85858585);
        check("t1_feedbo",  FEEDBO,  8'h85);
        check("t1_rowo",    ROWO,    0);
        check("t1_fb",      FBSTROBE, 1);
        step();
        check("t1_done_strobeo", STROBEO, 0);
        check("t1_rowo_adv",     ROWO,    1);
        check("t1_erro",         ERRO,    0);

        // 2: clipping high and low
        do_reset();
        push_base(32'hF0F0F0F0);
        push_base(32'h10101010);
        STROBEI = 1'b1;
        DATAI   = res4(9'h020, 9'h020, 9'h020, 9'h020);
        step();
        DATAI   = res4(9'h1E0, 9'h1E0, 9'h1E0, 9'h1E0);
        step();
        STROBEI = 1'b0;
        check("t2_hi", DATAO, 32'hFFFFFFFF);
        step();
        check("t2_lo", DATAO, 32'h00000000);
        check("t2_lo_strobeo", STROBEO, 1);
        step();
        check("t2_erro", ERRO, ErrExp);

        // 3: full block back-to-back
        do_reset();
        t3_base[0] = 32'h10203040; t3_res[0] = res4(9'd1, 9'd1, 9'd1, 9'd1);
        t3_exp[0]  = 32'h11213141;
        t3_base[1] = 32'h50607080; t3_res[1] = res4(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        t3_exp[1]  = 32'h4F5F6F7F;
        t3_base[2] = 32'h90A0B0C0; t3_res[2] = res4(9'd3, 9'd0, 9'h1FE, 9'd2);
        t3_exp[2]  = 32'h93A0AEC2;
        t3_base[3] = 32'hD0E0F000; t3_res[3] = res4(9'd0, 9'd0, 9'd0, 9'd0);
        t3_exp[3]  = 32'hD0E0F000;
        for (int k = 0; k < 4; k++) push_base(t3_base[k]);
        fb_count = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                STROBEI = 1'b1;
                DATAI   = t3_res[c];
                check($sformatf("t3_readyi%0d", c), READYI, 1);
            end else begin
                STROBEI = 1'b0;
            end
            if (FBSTROBE) fb_count++;
            if (c >= 2 && c < 6) begin
                check($sformatf("t3_data%0d", c - 2), DATAO, t3_exp[c-2]);
                check($sformatf("t3_row%0d", c - 2), ROWO, c - 2);
                check($sformatf("t3_blk%0d", c - 2), BLKDONE, (c - 2 == 3) ? 1 : 0);
            end
            step();
        end
        check("t3_fbcount", fb_count, 4);
        check("t3_rowo_wrap", ROWO, 0);
        check("t3_erro", ERRO, 0);

        // 4: downstream backpressure for 5 cycles
        do_reset();
        push_base(32'h01020304);
        push_base(32'h11121314);
        push_base(32'h21222324);
        READYO  = 1'b0;
        STROBEI = 1'b1;
        DATAI   = '0;
        check("t4_acc0", READYI, 1);
        step();
        check("t4_acc1", READYI, 1);
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_hold_data%0d", c), DATAO, 32'h01020304);
            check($sformatf("t4_hold_stb%0d", c), STROBEO, 1);
            check($sformatf("t4_hold_rdy%0d", c), READYI, 0);
            check($sformatf("t4_hold_fb%0d", c), FBSTROBE, 0);
            step();
        end
        READYO = 1'b1;
        #1;
        check("t4_rel_fb",   FBSTROBE, 1);
        check("t4_rel_rdy",  READYI,   1);
        check("t4_rel_data", DATAO,    32'h01020304);
        step();
        STROBEI = 1'b0;
        check("t4_row1", DATAO, 32'h11121314);
        check("t4_row1_stb", STROBEO, 1);
        step();
        check("t4_row2", DATAO, 32'h21222324);
        check("t4_row2_stb", STROBEO, 1);
        step();
        check("t4_drain", STROBEO, 0);
        check("t4_rowo", ROWO, 3);

        // 5: FIFO full, dropped push, residual on empty FIFO
        do_reset();
        for (int k = 1; k <= 8; k++) push_base(32'h01010101 * k);
        check("t5_full", BREADY, 0);
        BSTROBEI = 1'b1;
        BASEI    = 32'hDEADBEEF;
        step();
        BSTROBEI = 1'b0;
        check("t5_still_full", BREADY, 0);
        DATAI = '0;
        for (int c = 0; c < 11; c++) begin
            STROBEI = (c < 9);
            if (c < 8) check($sformatf("t5_rdy%0d", c), READYI, 1);
            if (c == 8) check("t5_empty_rdy", READYI, 0);
            if (c >= 2 && c < 10) check($sformatf("t5_data%0d", c - 2), DATAO,
                                        32'h01010101 * (c - 1));
            if (c == 10) check("t5_no_extra", STROBEO, 0);
            step();
        end
        STROBEI = 1'b0;
        check("t5_erro", ERRO, ErrExp);

        // 6: reset in the middle of a block
        do_reset();
        push_base(32'h40404040);
        push_base(32'h50505050);
        push_base(32'h60606060);
        STROBEI = 1'b1;
        DATAI   = '0;
        step();
        STROBEI = 1'b0;
        step();
        step();
        check("t6_rowo_pre", ROWO, 1);
        READYO  = 1'b0;
        STROBEI = 1'b1;
        step();
        STROBEI = 1'b0;
        step();
        check("t6_held", STROBEO, 1);
        RESETN = 1'b0;
        #1;
        check("t6_rst_stb",   STROBEO,  0);
        check("t6_rst_data",  DATAO,    0);
        check("t6_rst_rowo",  ROWO,     0);
        check("t6_rst_bredy", BREADY,   1);
        check("t6_rst_rdyi",  READYI,   0);
        check("t6_rst_fb",    FBSTROBE, 0);
        check("t6_rst_erro",  ERRO,     0);
        step();
        RESETN  = 1'b1;
        READYO  = 1'b1;
        STROBEI = 1'b1;
        step();
        check("t6_post_rdyi", READYI, 0);
        step();
        step();
        check("t6_post_stb",  STROBEO, 0);
        check("t6_post_rowo", ROWO,    0);
        STROBEI = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
